// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the memory arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_BUSY_IF,
        ARB_BUSY_DM
    } arb_state_t;

    typedef enum logic {
        SRC_IF,
        SRC_DM
    } arb_src_t;

    localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter of fetch and data ports onto one single-port memory
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_if_req,
    input  logic [31:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [31:0] o_if_rdata,
    input  logic        i_dm_req,
    input  logic        i_dm_we,
    input  logic [31:0] i_dm_addr,
    input  logic [31:0] i_dm_wdata,
    output logic        o_dm_gnt,
    output logic        o_dm_rvalid,
    output logic [31:0] o_dm_rdata,
    output logic        o_mem_req,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic        o_err
);

    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);

    arb_state_t  state;
    arb_state_t  state_next;
    arb_src_t    last_src;
    logic [15:0] wait_cnt;
    logic        gnt_if;
    logic        gnt_dm;
    logic        done;
    logic        timed_out;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Grants are only issued from IDLE; on a tie the port not served last wins.
    always_comb begin
        state_next = state;
        gnt_if     = 1'b0;
        gnt_dm     = 1'b0;
        done       = 1'b0;
        timed_out  = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (!i_rst) begin
                    if (i_if_req && i_dm_req) begin
                        gnt_dm = (last_src == SRC_IF);
                        gnt_if = (last_src == SRC_DM);
                    end else begin
                        gnt_if = i_if_req;
                        gnt_dm = i_dm_req;
                    end
                end
                if (gnt_if) begin
                    state_next = ARB_BUSY_IF;
                end else if (gnt_dm) begin
                    state_next = ARB_BUSY_DM;
                end
            end
            default: begin
                // An ack on the limit cycle wins over the timeout.
                if (i_mem_ack) begin
                    done       = 1'b1;
                    state_next = ARB_IDLE;
                end else if (wait_cnt == WAIT_LIMIT) begin
                    timed_out  = 1'b1;
                    state_next = ARB_IDLE;
                end
            end
        endcase
    end

    assign o_if_gnt  = gnt_if;
    assign o_dm_gnt  = gnt_dm;
    assign o_mem_req = (state != ARB_IDLE);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            last_src    <= SRC_IF;
            wait_cnt    <= '0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_wdata <= '0;
            o_if_rvalid <= 1'b0;
            o_if_rdata  <= '0;
            o_dm_rvalid <= 1'b0;
            o_dm_rdata  <= '0;
            o_err       <= 1'b0;
        end else begin
            o_if_rvalid <= 1'b0;
            o_dm_rvalid <= 1'b0;
            o_err       <= timed_out;
            if (gnt_if || gnt_dm) begin
                o_mem_addr  <= gnt_if ? i_if_addr : i_dm_addr;
                o_mem_we    <= gnt_dm & i_dm_we;
                o_mem_wdata <= gnt_dm ? i_dm_wdata : 32'h0;
                last_src    <= gnt_if ? SRC_IF : SRC_DM;
                wait_cnt    <= '0;
            end else if (state != ARB_IDLE && !i_mem_ack) begin
                wait_cnt <= wait_cnt + 16'd1;
            end
            if (done || timed_out) begin
                if (state == ARB_BUSY_IF) begin
                    o_if_rvalid <= 1'b1;
                    o_if_rdata  <= done ? i_mem_rdata : 32'h0;
                end else begin
                    o_dm_rvalid <= 1'b1;
                    o_dm_rdata  <= done ? i_mem_rdata : 32'h0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed self-checking bench for mem_arbiter
module tb_mem_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_if_req;
    logic [31:0] i_if_addr;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [31:0] o_if_rdata;
    logic        i_dm_req;
    logic        i_dm_we;
    logic [31:0] i_dm_addr;
    logic [31:0] i_dm_wdata;
    logic        o_dm_gnt;
    logic        o_dm_rvalid;
    logic [31:0] o_dm_rdata;
    logic        o_mem_req;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wdata;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic        o_err;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    mem_arbiter #(.TIMEOUT(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_if_req(i_if_req), .i_if_addr(i_if_addr), .o_if_gnt(o_if_gnt),
        .o_if_rvalid(o_if_rvalid), .o_if_rdata(o_if_rdata),
        .i_dm_req(i_dm_req), .i_dm_we(i_dm_we), .i_dm_addr(i_dm_addr),
        .i_dm_wdata(i_dm_wdata), .o_dm_gnt(o_dm_gnt),
        .o_dm_rvalid(o_dm_rvalid), .o_dm_rdata(o_dm_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
        .i_mem_rdata(i_mem_rdata), .o_err(o_err)
    );

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic apply_reset();
        i_rst = 1'b1;
        step();
        step();
        i_rst = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1; i_if_req = 1'b1; i_if_addr = 32'h44; i_dm_req = 1'b1;
        i_dm_we = 1'b1; i_dm_addr = 32'h88; i_dm_wdata = 32'h1234_5678;
        i_mem_ack = 1'b0; i_mem_rdata = 32'h0;
        step(); step();
        #1;
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {o_if_gnt, o_dm_gnt}); end
        checks++; if ({o_mem_req, o_mem_we, o_err, o_if_rvalid, o_dm_rvalid} !== 5'b0) begin errors++; $display("FAIL reset_flags got %b exp 00000", {o_mem_req, o_mem_we, o_err, o_if_rvalid, o_dm_rvalid}); end
        checks++; if ({o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata} !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {o_mem_addr, o_mem_wdata, o_if_rdata, o_dm_rdata}); end
        i_if_req = 1'b0; i_dm_req = 1'b0; i_dm_we = 1'b0;
        i_rst = 1'b0;
    endtask

    task automatic test_fetch();
        step();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0010;
        #1;
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b10) begin errors++; $display("FAIL fetch_gnt got %b exp 10", {o_if_gnt, o_dm_gnt}); end
        step();
        i_if_req = 1'b0;
        checks++; if ({o_mem_req, o_mem_we, o_mem_addr} !== {2'b10, 32'h10}) begin errors++; $display("FAIL fetch_mem got %h exp %h", {o_mem_req, o_mem_we, o_mem_addr}, {2'b10, 32'h10}); end
        checks++; if (o_if_gnt !== 1'b0) begin errors++; $display("FAIL fetch_busy_gnt got %b exp 0", o_if_gnt); end
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h0051_3093;
        checks++; if ({o_mem_req, o_if_rvalid} !== 2'b10) begin errors++; $display("FAIL fetch_wait got %b exp 10", {o_mem_req, o_if_rvalid}); end
        step();
        i_mem_ack = 1'b0; i_mem_rdata = 32'hFFFF_FFFF;
        checks++; if ({o_if_rvalid, o_dm_rvalid, o_mem_req, o_err} !== 4'b1000) begin errors++; $display("FAIL fetch_done got %b exp 1000", {o_if_rvalid, o_dm_rvalid, o_mem_req, o_err}); end
        checks++; if (o_if_rdata !== 32'h0051_3093) begin errors++; $display("FAIL fetch_rdata got %h exp 00513093", o_if_rdata); end
        step();
        checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b0, 32'h0051_3093}) begin errors++; $display("FAIL fetch_hold got %h exp %h", {o_if_rvalid, o_if_rdata}, {1'b0, 32'h0051_3093}); end
    endtask

    task automatic test_conflict();
        apply_reset();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0200;
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h0000_0100;
        #1;
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b01) begin errors++; $display("FAIL conflict_first got %b exp 01", {o_if_gnt, o_dm_gnt}); end
        step();
        i_dm_req = 1'b0;
        checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_if_gnt} !== {2'b10, 32'h100, 1'b0}) begin errors++; $display("FAIL conflict_dm_mem got %h exp %h", {o_mem_req, o_mem_we, o_mem_addr, o_if_gnt}, {2'b10, 32'h100, 1'b0}); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h1111_1111;
        step();
        i_mem_ack = 1'b0;
        #1;
        checks++; if ({o_dm_rvalid, o_dm_rdata} !== {1'b1, 32'h1111_1111}) begin errors++; $display("FAIL conflict_dm_done got %h exp %h", {o_dm_rvalid, o_dm_rdata}, {1'b1, 32'h1111_1111}); end
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b10) begin errors++; $display("FAIL conflict_if_gnt got %b exp 10", {o_if_gnt, o_dm_gnt}); end
        step();
        i_if_req = 1'b0;
        i_dm_req = 1'b1; i_dm_addr = 32'h0000_0104;
        #1;
        checks++; if ({o_mem_addr, o_dm_gnt} !== {32'h200, 1'b0}) begin errors++; $display("FAIL conflict_if_mem got %h exp %h", {o_mem_addr, o_dm_gnt}, {32'h200, 1'b0}); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h2222_2222;
        step();
        i_mem_ack = 1'b0;
        i_if_req = 1'b1; i_if_addr = 32'h0000_0204;
        #1;
        checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h2222_2222}) begin errors++; $display("FAIL conflict_if_done got %h exp %h", {o_if_rvalid, o_if_rdata}, {1'b1, 32'h2222_2222}); end
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b01) begin errors++; $display("FAIL conflict_rr_dm got %b exp 01", {o_if_gnt, o_dm_gnt}); end
        step();
        i_dm_req = 1'b0;
        checks++; if (o_mem_addr !== 32'h104) begin errors++; $display("FAIL conflict_dm2_addr got %h exp 00000104", o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h3333_3333;
        step();
        i_mem_ack = 1'b0;
        #1;
        checks++; if ({o_dm_rvalid, o_dm_rdata, o_if_gnt} !== {1'b1, 32'h3333_3333, 1'b1}) begin errors++; $display("FAIL conflict_rr_if got %h exp %h", {o_dm_rvalid, o_dm_rdata, o_if_gnt}, {1'b1, 32'h3333_3333, 1'b1}); end
        step();
        i_if_req = 1'b0;
        checks++; if (o_mem_addr !== 32'h204) begin errors++; $display("FAIL conflict_if2_addr got %h exp 00000204", o_mem_addr); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h4444_4444;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_if_rvalid, o_if_rdata} !== {1'b1, 32'h4444_4444}) begin errors++; $display("FAIL conflict_if2_done got %h exp %h", {o_if_rvalid, o_if_rdata}, {1'b1, 32'h4444_4444}); end
    endtask

    task automatic test_store();
        step();
        i_dm_req = 1'b1; i_dm_we = 1'b1; i_dm_addr = 32'h0000_0040; i_dm_wdata = 32'hDEAD_BEEF;
        #1;
        checks++; if ({o_if_gnt, o_dm_gnt} !== 2'b01) begin errors++; $display("FAIL store_gnt got %b exp 01", {o_if_gnt, o_dm_gnt}); end
        step();
        i_dm_req = 1'b0; i_dm_we = 1'b0; i_dm_wdata = 32'h0;
        checks++; if ({o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata} !== {2'b11, 32'h40, 32'hDEAD_BEEF}) begin errors++; $display("FAIL store_mem got %h exp %h", {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata}, {2'b11, 32'h40, 32'hDEAD_BEEF}); end
        step();
        checks++; if ({o_mem_req, o_mem_we, o_dm_rvalid} !== 3'b110) begin errors++; $display("FAIL store_hold got %b exp 110", {o_mem_req, o_mem_we, o_dm_rvalid}); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h5555_5555;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_dm_rvalid, o_err, o_mem_req} !== 3'b100) begin errors++; $display("FAIL store_done got %b exp 100", {o_dm_rvalid, o_err, o_mem_req}); end
        step();
        checks++; if (o_dm_rvalid !== 1'b0) begin errors++; $display("FAIL store_pulse got %b exp 0", o_dm_rvalid); end
    endtask

    task automatic test_timeout();
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h0000_0300;
        #1;
        checks++; if (o_dm_gnt !== 1'b1) begin errors++; $display("FAIL timeout_gnt got %b exp 1", o_dm_gnt); end
        step();
        i_dm_req = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checks++; if ({o_mem_req, o_dm_rvalid, o_err} !== 3'b100) begin errors++; $display("FAIL timeout_busy%0d got %b exp 100", c, {o_mem_req, o_dm_rvalid, o_err}); end
            step();
        end
        checks++; if ({o_mem_req, o_dm_rvalid, o_err} !== 3'b011) begin errors++; $display("FAIL timeout_abort got %b exp 011", {o_mem_req, o_dm_rvalid, o_err}); end
        checks++; if (o_dm_rdata !== 32'h0) begin errors++; $display("FAIL timeout_rdata got %h exp 00000000", o_dm_rdata); end
        i_mem_ack = 1'b1; i_mem_rdata = 32'h7777_7777;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_err, o_dm_rvalid, o_mem_req} !== 3'b000) begin errors++; $display("FAIL timeout_after got %b exp 000", {o_err, o_dm_rvalid, o_mem_req}); end
        step();
        checks++; if ({o_dm_rvalid, o_if_rvalid, o_dm_rdata} !== 34'h0) begin errors++; $display("FAIL late_ack got %h exp 0", {o_dm_rvalid, o_if_rvalid, o_dm_rdata}); end
    endtask

    task automatic test_ack_on_limit();
        i_dm_req = 1'b1; i_dm_we = 1'b0; i_dm_addr = 32'h0000_0400;
        step();
        i_dm_req = 1'b0;
        step(); step();
        checks++; if (o_mem_req !== 1'b1) begin errors++; $display("FAIL limit_busy got %b exp 1", o_mem_req); end
        step();
        i_mem_ack = 1'b1; i_mem_rdata = 32'h6666_6666;
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_dm_rvalid, o_err, o_mem_req} !== 3'b100) begin errors++; $display("FAIL limit_done got %b exp 100", {o_dm_rvalid, o_err, o_mem_req}); end
        checks++; if (o_dm_rdata !== 32'h6666_6666) begin errors++; $display("FAIL limit_rdata got %h exp 66666666", o_dm_rdata); end
    endtask

    task automatic test_reset_mid();
        step();
        i_if_req = 1'b1; i_if_addr = 32'h0000_0500;
        step();
        i_if_req = 1'b0;
        checks++; if ({o_mem_req, o_mem_addr} !== {1'b1, 32'h500}) begin errors++; $display("FAIL rstmid_busy got %h exp %h", {o_mem_req, o_mem_addr}, {1'b1, 32'h500}); end
        i_rst = 1'b1; i_mem_ack = 1'b1; i_mem_rdata = 32'h8888_8888;
        step();
        i_rst = 1'b0;
        checks++; if ({o_mem_req, o_if_rvalid, o_dm_rvalid, o_err, o_if_gnt, o_dm_gnt} !== 6'b0) begin errors++; $display("FAIL rstmid_flags got %b exp 000000", {o_mem_req, o_if_rvalid, o_dm_rvalid, o_err, o_if_gnt, o_dm_gnt}); end
        checks++; if ({o_mem_addr, o_if_rdata, o_dm_rdata} !== 96'h0) begin errors++; $display("FAIL rstmid_data got %h exp 0", {o_mem_addr, o_if_rdata, o_dm_rdata}); end
        step();
        i_mem_ack = 1'b0;
        checks++; if ({o_mem_req, o_if_rvalid, o_if_rdata} !== 34'h0) begin errors++; $display("FAIL rstmid_ack got %h exp 0", {o_mem_req, o_if_rvalid, o_if_rdata}); end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_conflict();
        test_store();
        test_timeout();
        test_ack_on_limit();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
